// File: rtl/alu_arithmetic_unit_if.sv
// alu_arithmetic_unit_if: operand/result bundle for the 4-bit arithmetic slice.
interface alu_arithmetic_unit_if;
   logic       in_valid;
   logic [3:0] A;
   logic [3:0] B;
   logic       carry_in;
   logic [2:0] opcode;
   logic [3:0] result;
   logic [3:0] left_over;
   logic       carry_out;
   logic       out_valid;
   modport master (output in_valid, A, B, carry_in, opcode, input result, left_over, carry_out, out_valid);
   modport slave (input in_valid, A, B, carry_in, opcode, output result, left_over, carry_out, out_valid);
endinterface

// File: rtl/alu_arithmetic_unit.sv
// alu_arithmetic_unit: registered 4-bit add/sub/mul/div, one-cycle latency.
// Define ALU_ARITH_DIV_EN to build the divider; otherwise opcode 011 is unsupported.
module alu_arithmetic_unit (
   input logic clk,
   input logic rst_n,
   alu_arithmetic_unit_if.slave bus
);
   logic [3:0] result_d, result_q, left_over_d, left_over_q;
   logic       carry_out_d, carry_out_q, out_valid_d, out_valid_q;
   logic [4:0] sum, diff;
   logic [7:0] prod;
   always_comb begin
      sum = {1'b0, bus.A} + {1'b0, bus.B} + {4'b0, bus.carry_in};
      // Bit 4 of the 5-bit difference is the borrow out
      diff = {1'b0, bus.A} - {1'b0, bus.B} - {4'b0, bus.carry_in};
      prod = {4'b0, bus.A} * {4'b0, bus.B};
      result_d = result_q;
      left_over_d = left_over_q;
      carry_out_d = carry_out_q;
      out_valid_d = bus.in_valid;
      if (bus.in_valid) begin
         result_d = 4'd0;
         left_over_d = 4'd0;
         carry_out_d = 1'b0;
         case (bus.opcode)
            3'b000: {carry_out_d, result_d} = sum;
            3'b001: {carry_out_d, result_d} = diff;
            3'b010: begin
               {left_over_d, result_d} = prod;
               carry_out_d = |prod[7:4];
            end
`ifdef ALU_ARITH_DIV_EN
            3'b011: begin
               result_d = (bus.B == 4'd0) ? 4'hf : bus.A / bus.B;
               left_over_d = (bus.B == 4'd0) ? bus.A : bus.A % bus.B;
               carry_out_d = (bus.B == 4'd0);
            end
`endif
            default: ;
         endcase
      end
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         result_q <= 4'd0;
         left_over_q <= 4'd0;
         carry_out_q <= 1'b0;
         out_valid_q <= 1'b0;
      end else begin
         result_q <= result_d;
         left_over_q <= left_over_d;
         carry_out_q <= carry_out_d;
         out_valid_q <= out_valid_d;
      end
   end
   assign bus.result = result_q;
   assign bus.left_over = left_over_q;
   assign bus.carry_out = carry_out_q;
   assign bus.out_valid = out_valid_q;
endmodule

// File: tb/tb_alu_arithmetic_unit.sv
// tb_alu_arithmetic_unit: scoreboard bench for the arithmetic slice.
module tb_alu_arithmetic_unit;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int checks = 0;
   int errors = 0;
   int n_pushed = 0;
   int n_seen = 0;
   logic [8:0] last_exp = 9'd0;
   typedef struct {
      string      tag;
      logic [8:0] exp;
   } item_t;
   item_t sb[$];
   alu_arithmetic_unit_if bus ();
   alu_arithmetic_unit dut (.clk(clk), .rst_n(rst_n), .bus(bus));
   always #5 clk = ~clk;
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %h expected %h", tag, got, exp);
      end
   endtask
   // Expected value packed as {carry_out, left_over, result}
   function automatic logic [8:0] model(input logic [2:0] op, input int a, input int b, input int ci);
      int t;
      case (op)
         3'b000: begin t = a + b + ci; return {t > 15, 4'd0, 4'(t)}; end
         3'b001: begin t = a - b - ci; return {t < 0, 4'd0, 4'(t)}; end
         3'b010: begin t = a * b; return {t > 15, 4'(t / 16), 4'(t)}; end
`ifdef ALU_ARITH_DIV_EN
         3'b011: return (b == 0) ? {1'b1, 4'(a), 4'hf} : {1'b0, 4'(a % b), 4'(a / b)};
`endif
         default: return 9'd0;
      endcase
   endfunction
   task automatic drive(input string tag, input logic [2:0] op, input logic [3:0] a, input logic [3:0] b, input logic ci);
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.opcode = op;
      bus.A = a;
      bus.B = b;
      bus.carry_in = ci;
      last_exp = model(op, int'(a), int'(b), int'(ci));
      sb.push_back('{tag, last_exp});
      n_pushed++;
   endtask
   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         bus.in_valid = 1'b0;
         bus.A = 4'($urandom);
         bus.B = 4'($urandom);
      end
   endtask
   always @(posedge clk) begin
      #1;
      if (rst_n && bus.out_valid) begin
         n_seen++;
         if (sb.size() == 0) check("unexpected_valid", 1, 0);
         else begin
            item_t it;
            it = sb.pop_front();
            check(it.tag, {bus.carry_out, bus.left_over, bus.result}, it.exp);
         end
      end
   end
   initial begin
      bus.in_valid = 1'b0;
      bus.opcode = 3'd0;
      bus.A = 4'd0;
      bus.B = 4'd0;
      bus.carry_in = 1'b0;
      repeat (2) @(posedge clk);
      #1 check("reset_state", {bus.out_valid, bus.carry_out, bus.left_over, bus.result}, 0);
      @(negedge clk) rst_n = 1'b1;
      drive("add_nz", 3'b000, 4'b1010, 4'b0101, 1'b0);
      idle(1);
      @(posedge clk);
      #3 rst_n = 1'b0;
      #1 check("async_reset", {bus.out_valid, bus.carry_out, bus.left_over, bus.result}, 0);
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk);
      #1 check("post_reset_idle", {bus.out_valid, bus.carry_out, bus.left_over, bus.result}, 0);
      // Operation directed vectors, back to back
      drive("add_ci0", 3'b000, 4'b1010, 4'b0101, 1'b0);
      drive("add_ci1", 3'b000, 4'b1010, 4'b0101, 1'b1);
      drive("add_max", 3'b000, 4'b1111, 4'b1111, 1'b1);
      drive("sub_pos", 3'b001, 4'b1010, 4'b0101, 1'b0);
      drive("sub_neg", 3'b001, 4'b0011, 4'b0101, 1'b0);
      drive("sub_bin", 3'b001, 4'b0101, 4'b0101, 1'b1);
      drive("mul_ovf", 3'b010, 4'b1010, 4'b0101, 1'b0);
      drive("mul_fit", 3'b010, 4'b0011, 4'b0101, 1'b1);
      drive("mul_max", 3'b010, 4'b1111, 4'b1111, 1'b0);
      drive("div_even", 3'b011, 4'b1010, 4'b0101, 1'b0);
      drive("div_rem", 3'b011, 4'b1011, 4'b0011, 1'b1);
      drive("div_zero", 3'b011, 4'b1001, 4'b0000, 1'b0);
      drive("op101", 3'b101, 4'b1111, 4'b1111, 1'b1);
      drive("op111", 3'b111, 4'b0110, 4'b0011, 1'b0);
      // Three consecutive valids then a gap
      drive("burst0", 3'b000, 4'b0111, 4'b0001, 1'b0);
      drive("burst1", 3'b010, 4'b0100, 4'b0110, 1'b0);
      drive("burst2", 3'b001, 4'b0010, 4'b0111, 1'b1);
      idle(1);
      @(posedge clk);
      @(posedge clk);
      #1 check("gap_no_valid", bus.out_valid, 0);
      check("gap_hold", {bus.carry_out, bus.left_over, bus.result}, last_exp);
      for (int i = 0; i < 40; i++)
         drive("random", 3'($urandom_range(0, 7)), 4'($urandom), 4'($urandom), 1'($urandom));
      idle(3);
      // Reset with a capture pending: nothing may emerge
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.opcode = 3'b000;
      bus.A = 4'd3;
      bus.B = 4'd4;
      #2 rst_n = 1'b0;
      @(negedge clk);
      bus.in_valid = 1'b0;
      rst_n = 1'b1;
      @(posedge clk);
      #1 check("reset_discard", {bus.out_valid, bus.carry_out, bus.left_over, bus.result}, 0);
      repeat (2) @(posedge clk);
      #2 check("valid_count", n_seen, n_pushed);
      check("sb_empty", sb.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
